serial_subtractor: RTL and testbench

//   Multi-cycle, digit-serial WIDTH-bit subtractor: diff = a - b (mod 2^WIDTH).

---
 rtl/serial_subtractor.sv | 154 +++++++++++++++
 tb/tb_serial_subtractor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Digit-serial WIDTH-bit subtractor computing diff = a - b (mod 2^WIDTH).
//   It handles DIGIT bits per clock, LSB first, and forms the result as
//   a + ~b + 1. After each operation it also reports an unsigned borrow
//   (a < b) and two's-complement signed overflow.
//   Only one operation is in flight at a time.
//   The result appears N = WIDTH/DIGIT cycles after the accept edge.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   in_valid   in   operands a/b are valid
//   in_ready   out  an operation can be accepted (high only in IDLE)
//   a, b       in   minuend / subtrahend, sampled on the accept edge
//   out_valid  out  result valid (high only in DONE)
//   out_ready  in   consumer takes the result
//   diff       out  a - b mod 2^WIDTH
//   borrow     out  1 when a < b (unsigned)
//   ovf        out  signed overflow of a - b
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] acc_reg;      // partial result, filled from the MSB end
    logic             carry_reg;
    logic [CW-1:0]    count_reg;
    logic             a_msb_reg;    // operand signs, kept because a_sh/b_sh are shifted away
    logic             b_msb_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             ovf_reg;

    logic [DIGIT:0]   slice_sum;
    logic [WIDTH-1:0] acc_next;
    logic             last_digit;

    // One digit of a + ~b + carry. The top bit is the carry into the next digit.
    assign slice_sum = {1'b0, a_sh_reg[DIGIT-1:0]}
                     + {1'b0, ~b_sh_reg[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_reg};

    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign acc_next = slice_sum[DIGIT-1:0];
        end else begin : g_multi_digit
            assign acc_next = {slice_sum[DIGIT-1:0], acc_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign last_digit = (count_reg == CW'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_digit) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            acc_reg    <= '0;
            carry_reg  <= 1'b0;
            count_reg  <= '0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        a_msb_reg <= a[WIDTH-1];
                        b_msb_reg <= b[WIDTH-1];
                        carry_reg <= 1'b1;      // the +1 of the two's complement of b
                        count_reg <= '0;
                    end
                end
                RUN: begin
                    a_sh_reg  <= a_sh_reg >> DIGIT;
                    b_sh_reg  <= b_sh_reg >> DIGIT;
                    acc_reg   <= acc_next;
                    carry_reg <= slice_sum[DIGIT];
                    count_reg <= count_reg + CW'(1);
                    // Publish the result on the final edge, so that the
                    // visible outputs never show a partial result.
                    if (last_digit) begin
                        diff_reg   <= acc_next;
                        borrow_reg <= ~slice_sum[DIGIT];
                        ovf_reg    <= (a_msb_reg ^ b_msb_reg) & (acc_next[WIDTH-1] ^ a_msb_reg);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign diff      = diff_reg;
    assign borrow    = borrow_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;

    logic        in_valid_d1, in_ready_d1, out_valid_d1, out_ready_d1;
    logic [31:0] a_d1, b_d1, diff_d1;
    logic        borrow_d1, ovf_d1;

    logic        in_valid_d4, in_ready_d4, out_valid_d4, out_ready_d4;
    logic [31:0] a_d4, b_d4, diff_d4;
    logic        borrow_d4, ovf_d4;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(32), .DIGIT(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_d1),
        .in_ready  (in_ready_d1),
        .a         (a_d1),
        .b         (b_d1),
        .out_valid (out_valid_d1),
        .out_ready (out_ready_d1),
        .diff      (diff_d1),
        .borrow    (borrow_d1),
        .ovf       (ovf_d1)
    );

    serial_subtractor #(.WIDTH(32), .DIGIT(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_d4),
        .in_ready  (in_ready_d4),
        .a         (a_d4),
        .b         (b_d4),
        .out_valid (out_valid_d4),
        .out_ready (out_ready_d4),
        .diff      (diff_d4),
        .borrow    (borrow_d4),
        .ovf       (ovf_d4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one operation on the selected instance. The caller must enter
    // 1 time unit after a rising edge. The task reports the in_ready value
    // seen at accept time, the latency in cycles (-1 on timeout) and the
    // outputs seen when out_valid rose. When consume is set, the task
    // takes the result, so the instance returns to IDLE.
    task automatic run_op(input bit sel4, input logic [31:0] av, input logic [31:0] bv,
                          input bit consume, output int lat, output logic [31:0] d,
                          output logic bo, output logic ov, output logic rdy);
        int n;
        n   = sel4 ? 8 : 32;
        lat = -1;
        if (sel4) begin
            in_valid_d4 = 1'b1; a_d4 = av; b_d4 = bv; rdy = in_ready_d4;
        end else begin
            in_valid_d1 = 1'b1; a_d1 = av; b_d1 = bv; rdy = in_ready_d1;
        end
        @(posedge clk); #1;
        // Scramble the operands after accept; they must have no effect.
        if (sel4) begin
            in_valid_d4 = 1'b0; a_d4 = ~av; b_d4 = ~bv;
        end else begin
            in_valid_d1 = 1'b0; a_d1 = ~av; b_d1 = ~bv;
        end
        for (int i = 1; i <= n + 10; i++) begin
            @(posedge clk); #1;
            if (sel4 ? out_valid_d4 : out_valid_d1) begin
                lat = i;
                break;
            end
        end
        d  = sel4 ? diff_d4 : diff_d1;
        bo = sel4 ? borrow_d4 : borrow_d1;
        ov = sel4 ? ovf_d4 : ovf_d1;
        $display("op dut%0d: a=%h b=%h -> diff=%h borrow=%b ovf=%b latency=%0d",
                 sel4 ? 4 : 1, av, bv, d, bo, ov, lat);
        if (consume) begin
            if (sel4) out_ready_d4 = 1'b1; else out_ready_d1 = 1'b1;
            @(posedge clk); #1;
            out_ready_d4 = 1'b0;
            out_ready_d1 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid_d1 = 1'b0; out_ready_d1 = 1'b0; a_d1 = '0; b_d1 = '0;
        in_valid_d4 = 1'b0; out_ready_d4 = 1'b0; a_d4 = '0; b_d4 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (in_ready_d1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_d1); end
        checks++; if (out_valid_d1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_d1); end
        checks++; if (diff_d1 !== 32'h0) begin errors++; $display("FAIL reset_diff: got %h want 0", diff_d1); end
        checks++; if (borrow_d1 !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b want 0", borrow_d1); end
        checks++; if (ovf_d1 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_d1); end
        checks++; if (in_ready_d4 !== 1'b1 || out_valid_d4 !== 1'b0) begin errors++; $display("FAIL reset_d4_handshake: got in_ready=%b out_valid=%b want 1 0", in_ready_d4, out_valid_d4); end
        $display("reset: in_ready=%b out_valid=%b diff=%h", in_ready_d1, out_valid_d1, diff_d1);
    endtask

    task automatic test_basic();
        int lat; logic [31:0] d; logic bo, ov, rdy;
        run_op(1'b0, 32'd100, 32'd58, 1'b1, lat, d, bo, ov, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", rdy); end
        checks++; if (d !== 32'd42) begin errors++; $display("FAIL basic_diff: got %h want %h", d, 32'd42); end
        checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b want 0", bo); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ov); end
        checks++; if (lat != 32) begin errors++; $display("FAIL basic_latency: got %0d want 32", lat); end
    endtask

    task automatic test_borrow();
        int lat; logic [31:0] d; logic bo, ov, rdy;
        run_op(1'b0, 32'd5, 32'd7, 1'b1, lat, d, bo, ov, rdy);
        checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL borrow_diff: got %h want fffffffe", d); end
        checks++; if (bo !== 1'b1) begin errors++; $display("FAIL borrow_flag: got %b want 1", bo); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL borrow_ovf: got %b want 0", ov); end
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] d; logic bo, ov, rdy;
        run_op(1'b0, 32'h8000_0000, 32'd1, 1'b1, lat, d, bo, ov, rdy);
        checks++; if (d !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ovf_diff: got %h want 7fffffff", d); end
        checks++; if (bo !== 1'b0) begin errors++; $display("FAIL ovf_borrow: got %b want 0", bo); end
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ov); end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] d; logic bo, ov, rdy;
        run_op(1'b0, 32'd3, 32'd10, 1'b0, lat, d, bo, ov, rdy);
        checks++; if (d !== 32'hFFFF_FFF9 || bo !== 1'b1) begin errors++; $display("FAIL bp_result: got diff=%h borrow=%b want fffffff9 1", d, bo); end
        for (int c = 0; c < 10; c++) begin
            in_valid_d1 = (c == 3);
            a_d1 = 32'd1; b_d1 = 32'd1;
            @(posedge clk); #1;
            checks++;
            if (out_valid_d1 !== 1'b1 || in_ready_d1 !== 1'b0 || diff_d1 !== 32'hFFFF_FFF9 || borrow_d1 !== 1'b1 || ovf_d1 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_c%0d: got out_valid=%b in_ready=%b diff=%h borrow=%b ovf=%b want 1 0 fffffff9 1 0",
                         c, out_valid_d1, in_ready_d1, diff_d1, borrow_d1, ovf_d1);
            end
        end
        in_valid_d1 = 1'b0;
        out_ready_d1 = 1'b1;
        @(posedge clk); #1;
        out_ready_d1 = 1'b0;
        checks++; if (out_valid_d1 !== 1'b0 || in_ready_d1 !== 1'b1) begin errors++; $display("FAIL bp_consume: got out_valid=%b in_ready=%b want 0 1", out_valid_d1, in_ready_d1); end
        @(posedge clk); #1;
        checks++; if (in_ready_d1 !== 1'b1) begin errors++; $display("FAIL bp_pulse_ignored: got in_ready=%b want 1", in_ready_d1); end
        $display("backpressure: result held 10 cycles, then consumed");
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] d; logic bo, ov, rdy;
        run_op(1'b0, 32'd1000, 32'd1, 1'b1, lat, d, bo, ov, rdy);
        checks++; if (d !== 32'd999) begin errors++; $display("FAIL b2b_first: got %h want %h", d, 32'd999); end
        run_op(1'b0, 32'd50, 32'd20, 1'b1, lat, d, bo, ov, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", rdy); end
        checks++; if (d !== 32'd30 || bo !== 1'b0) begin errors++; $display("FAIL b2b_second: got diff=%h borrow=%b want 0000001e 0", d, bo); end
        checks++; if (lat != 32) begin errors++; $display("FAIL b2b_latency: got %0d want 32", lat); end
    endtask

    task automatic test_reset_midrun();
        int lat; logic [31:0] d; logic bo, ov, rdy;
        in_valid_d1 = 1'b1; a_d1 = 32'h1234_5678; b_d1 = 32'd1;
        @(posedge clk); #1;
        in_valid_d1 = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (in_ready_d1 !== 1'b1 || out_valid_d1 !== 1'b0) begin errors++; $display("FAIL midrst_handshake: got in_ready=%b out_valid=%b want 1 0", in_ready_d1, out_valid_d1); end
        checks++; if (diff_d1 !== 32'h0) begin errors++; $display("FAIL midrst_diff: got %h want 0", diff_d1); end
        $display("reset mid-run: in_ready=%b out_valid=%b", in_ready_d1, out_valid_d1);
        run_op(1'b0, 32'd9, 32'd3, 1'b1, lat, d, bo, ov, rdy);
        checks++; if (d !== 32'd6 || bo !== 1'b0) begin errors++; $display("FAIL midrst_after: got diff=%h borrow=%b want 00000006 0", d, bo); end
        checks++; if (lat != 32) begin errors++; $display("FAIL midrst_latency: got %0d want 32", lat); end
    endtask

    task automatic test_digit4();
        int lat; logic [31:0] d; logic bo, ov, rdy;
        run_op(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, lat, d, bo, ov, rdy);
        checks++; if (d !== 32'h0 || bo !== 1'b0 || ov !== 1'b0) begin errors++; $display("FAIL d4_equal: got diff=%h borrow=%b ovf=%b want 0 0 0", d, bo, ov); end
        checks++; if (lat != 8) begin errors++; $display("FAIL d4_latency: got %0d want 8", lat); end
        run_op(1'b1, 32'h10, 32'h20, 1'b1, lat, d, bo, ov, rdy);
        checks++; if (d !== 32'hFFFF_FFF0 || bo !== 1'b1 || ov !== 1'b0) begin errors++; $display("FAIL d4_borrow: got diff=%h borrow=%b ovf=%b want fffffff0 1 0", d, bo, ov); end
        run_op(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, d, bo, ov, rdy);
        checks++; if (d !== 32'h8000_0000 || bo !== 1'b1 || ov !== 1'b1) begin errors++; $display("FAIL d4_ovf: got diff=%h borrow=%b ovf=%b want 80000000 1 1", d, bo, ov); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        test_digit4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
